// File: rtl/account_db_pkg.sv
// Shared types and defaults for the account store and the ATM session FSM.
package account_db_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_PIN,
        S_CHECK,
        S_AUTH,
        S_LOCKED
    } state_t;

    localparam int BALANCE_WIDTH = 20;
    localparam int PIN_WIDTH     = 16;
    localparam int MAX_TRIES     = 3;

endpackage

// File: rtl/account_regfile.sv
// Per-account PIN, balance, fail count and lock flag, with one registered read port.
module account_regfile
    import account_db_pkg::*;
#(
    parameter int balance_width = BALANCE_WIDTH,
    parameter int num_accounts  = 4,
    parameter int id_width      = 2,
    parameter int pin_width     = PIN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [id_width-1:0]      i_rd_id,
    output logic [pin_width-1:0]     o_rd_pin,
    output logic [balance_width-1:0] o_rd_balance,
    output logic [1:0]               o_rd_fail,
    output logic                     o_rd_lock,
    input  logic [id_width-1:0]      i_sess_id,
    input  logic                     i_commit_we,
    input  logic [balance_width-1:0] i_commit_balance,
    input  logic                     i_fail_we,
    input  logic [1:0]               i_fail_val,
    input  logic                     i_lock_val,
    input  logic                     i_prov_we,
    input  logic [id_width-1:0]      i_prov_id,
    input  logic [pin_width-1:0]     i_prov_pin,
    input  logic [balance_width-1:0] i_prov_balance
);

    localparam logic [id_width:0] NUM_ACC = (id_width + 1)'(num_accounts);

    logic [pin_width-1:0]     r_pin     [num_accounts];
    logic [balance_width-1:0] r_balance [num_accounts];
    logic [1:0]               r_fail    [num_accounts];
    logic                     r_lock    [num_accounts];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_pin     <= '0;
            o_rd_balance <= '0;
            o_rd_fail    <= '0;
            o_rd_lock    <= 1'b0;
            for (int i = 0; i < num_accounts; i++) begin
                r_pin[i]     <= '0;
                r_balance[i] <= '0;
                r_fail[i]    <= '0;
                r_lock[i]    <= 1'b0;
            end
        end else begin
            // Ids beyond the stored accounts read back as an all-zero record.
            if ({1'b0, i_rd_id} < NUM_ACC) begin
                o_rd_pin     <= r_pin[i_rd_id];
                o_rd_balance <= r_balance[i_rd_id];
                o_rd_fail    <= r_fail[i_rd_id];
                o_rd_lock    <= r_lock[i_rd_id];
            end else begin
                o_rd_pin     <= '0;
                o_rd_balance <= '0;
                o_rd_fail    <= '0;
                o_rd_lock    <= 1'b0;
            end
            if (i_prov_we) begin
                r_pin[i_prov_id]     <= i_prov_pin;
                r_balance[i_prov_id] <= i_prov_balance;
                r_fail[i_prov_id]    <= '0;
                r_lock[i_prov_id]    <= 1'b0;
            end
            if (i_commit_we) begin
                r_balance[i_sess_id] <= i_commit_balance;
            end
            if (i_fail_we) begin
                r_fail[i_sess_id] <= i_fail_val;
                r_lock[i_sess_id] <= i_lock_val;
            end
        end
    end

endmodule

// File: rtl/account_db.sv
// Account store and PIN checker: session FSM, registered outputs and the account register file.
module account_db
    import account_db_pkg::*;
#(
    parameter int balance_width = BALANCE_WIDTH,
    parameter int num_accounts  = 4,
    parameter int id_width      = 2,
    parameter int pin_width     = PIN_WIDTH,
    parameter int max_tries     = MAX_TRIES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     card_in,
    input  logic [id_width-1:0]      card_id,
    input  logic                     pin_valid,
    input  logic [pin_width-1:0]     pin_in,
    input  logic                     commit_en,
    input  logic [balance_width-1:0] commit_balance,
    input  logic                     prov_en,
    input  logic [id_width-1:0]      prov_id,
    input  logic [pin_width-1:0]     prov_pin,
    input  logic [balance_width-1:0] prov_balance,
    output logic [balance_width-1:0] current_balance,
    output logic                     check_done,
    output logic                     wrong_psw,
    output logic                     authed,
    output logic                     locked,
    output logic                     busy
);

    localparam logic [id_width:0] NUM_ACC = (id_width + 1)'(num_accounts);
    localparam logic [1:0]        MAX_T   = 2'(max_tries);

    state_t                   r_state;
    logic [id_width-1:0]      r_sess_id;
    logic [balance_width-1:0] r_cur_bal;
    logic                     r_check_done;
    logic                     r_wrong_psw;
    logic                     r_authed;
    logic                     r_locked;
    logic                     r_busy;

    logic [id_width-1:0]      w_rd_id;
    logic [pin_width-1:0]     w_rd_pin;
    logic [balance_width-1:0] w_rd_balance;
    logic [1:0]               w_rd_fail;
    logic                     w_rd_lock;
    logic [1:0]               w_fail_next;
    logic                     w_prov_we;
    logic                     w_commit_we;
    logic                     w_fail_we;

    // Address by card_id while idle so the record is already registered when LOAD runs.
    assign w_rd_id     = (r_state == S_IDLE) ? card_id : r_sess_id;
    assign w_fail_next = (w_rd_fail >= MAX_T) ? MAX_T : w_rd_fail + 2'd1;
    assign w_prov_we   = (r_state == S_IDLE) && !card_in && prov_en && ({1'b0, prov_id} < NUM_ACC);
    assign w_commit_we = (r_state == S_AUTH) && commit_en;
    // The attempt is recorded even if the card is pulled during CHECK, so pulling it cannot reset the count.
    assign w_fail_we   = (r_state == S_CHECK);

    account_regfile #(
        .balance_width (balance_width),
        .num_accounts  (num_accounts),
        .id_width      (id_width),
        .pin_width     (pin_width)
    ) u_regfile (
        .clk              (clk),
        .rst              (rst),
        .i_rd_id          (w_rd_id),
        .o_rd_pin         (w_rd_pin),
        .o_rd_balance     (w_rd_balance),
        .o_rd_fail        (w_rd_fail),
        .o_rd_lock        (w_rd_lock),
        .i_sess_id        (r_sess_id),
        .i_commit_we      (w_commit_we),
        .i_commit_balance (commit_balance),
        .i_fail_we        (w_fail_we),
        .i_fail_val       (r_wrong_psw ? w_fail_next : 2'd0),
        .i_lock_val       (r_wrong_psw && (w_fail_next == MAX_T)),
        .i_prov_we        (w_prov_we),
        .i_prov_id        (prov_id),
        .i_prov_pin       (prov_pin),
        .i_prov_balance   (prov_balance)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sess_id    <= '0;
            r_cur_bal    <= '0;
            r_check_done <= 1'b0;
            r_wrong_psw  <= 1'b0;
            r_authed     <= 1'b0;
            r_locked     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_check_done <= 1'b0;
            r_wrong_psw  <= 1'b0;
            if (r_state != S_IDLE && !card_in) begin
                r_state   <= S_IDLE;
                r_cur_bal <= '0;
                r_authed  <= 1'b0;
                r_locked  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (card_in) begin
                            r_sess_id <= card_id;
                            r_busy    <= 1'b1;
                            if ({1'b0, card_id} >= NUM_ACC) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_cur_bal <= w_rd_balance;
                        if (w_rd_lock) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_PIN;
                        end
                    end
                    S_WAIT_PIN: begin
                        if (pin_valid) begin
                            r_state      <= S_CHECK;
                            r_check_done <= 1'b1;
                            r_wrong_psw  <= (pin_in != w_rd_pin);
                        end
                    end
                    S_CHECK: begin
                        if (!r_wrong_psw) begin
                            r_state  <= S_AUTH;
                            r_authed <= 1'b1;
                        end else if (w_fail_next == MAX_T) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_PIN;
                        end
                    end
                    S_AUTH: begin
                        if (commit_en) begin
                            r_cur_bal <= commit_balance;
                        end
                    end
                    S_LOCKED: begin
                        if (pin_valid) begin
                            r_check_done <= 1'b1;
                            r_wrong_psw  <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign current_balance = r_cur_bal;
    assign check_done      = r_check_done;
    assign wrong_psw       = r_wrong_psw;
    assign authed          = r_authed;
    assign locked          = r_locked;
    assign busy            = r_busy;

endmodule

// File: tb/tb_account_db.sv
// Directed plus randomized bench for account_db against an account-level reference model.
module tb_account_db;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        card_in = 1'b0;
    logic [1:0]  card_id = '0;
    logic        pin_valid = 1'b0;
    logic [15:0] pin_in = '0;
    logic        commit_en = 1'b0;
    logic [19:0] commit_balance = '0;
    logic        prov_en = 1'b0;
    logic [1:0]  prov_id = '0;
    logic [15:0] prov_pin = '0;
    logic [19:0] prov_balance = '0;
    logic [19:0] current_balance;
    logic        check_done;
    logic        wrong_psw;
    logic        authed;
    logic        locked;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: account records plus the session as seen by the FSM.
    logic [15:0] m_pin  [4];
    logic [19:0] m_bal  [4];
    int          m_fail [4];
    bit          m_lock [4];
    bit          m_in, m_auth, m_lk;
    int          m_sid;
    logic [19:0] m_cur;

    account_db dut (
        .clk             (clk),
        .rst             (rst),
        .card_in         (card_in),
        .card_id         (card_id),
        .pin_valid       (pin_valid),
        .pin_in          (pin_in),
        .commit_en       (commit_en),
        .commit_balance  (commit_balance),
        .prov_en         (prov_en),
        .prov_id         (prov_id),
        .prov_pin        (prov_pin),
        .prov_balance    (prov_balance),
        .current_balance (current_balance),
        .check_done      (check_done),
        .wrong_psw       (wrong_psw),
        .authed          (authed),
        .locked          (locked),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_pin[i] = '0; m_bal[i] = '0; m_fail[i] = 0; m_lock[i] = 1'b0;
        end
        m_in = 1'b0; m_auth = 1'b0; m_lk = 1'b0; m_sid = 0; m_cur = '0;
    endtask

    task automatic prov(input int id, input logic [15:0] p, input logic [19:0] b);
        prov_en = 1'b1; prov_id = 2'(id); prov_pin = p; prov_balance = b;
        tick();
        prov_en = 1'b0;
        m_pin[id] = p; m_bal[id] = b; m_fail[id] = 0; m_lock[id] = 1'b0;
        chk("prov_busy", busy, 0);
    endtask

    task automatic insert(input int id);
        card_in = 1'b1; card_id = 2'(id);
        tick();
        chk("ins_busy", busy, 1);
        tick();
        m_in = 1'b1; m_sid = id; m_auth = 1'b0; m_lk = m_lock[id]; m_cur = m_bal[id];
        chk("ins_balance", current_balance, m_cur);
        chk("ins_locked", locked, m_lk);
        chk("ins_authed", authed, 0);
    endtask

    task automatic enter_pin(input logic [15:0] p);
        bit exp_cd, exp_w;
        pin_valid = 1'b1; pin_in = p;
        tick();
        pin_valid = 1'b0;
        if (m_auth) begin
            exp_cd = 0; exp_w = 0;
        end else if (m_lk) begin
            exp_cd = 1; exp_w = 1;
        end else begin
            exp_cd = 1; exp_w = (p != m_pin[m_sid]);
            if (!exp_w) begin
                m_fail[m_sid] = 0; m_auth = 1'b1;
            end else begin
                m_fail[m_sid] = (m_fail[m_sid] + 1 > 3) ? 3 : m_fail[m_sid] + 1;
                if (m_fail[m_sid] == 3) begin
                    m_lock[m_sid] = 1'b1; m_lk = 1'b1;
                end
            end
        end
        chk("pin_check_done", check_done, exp_cd);
        chk("pin_wrong_psw", wrong_psw, exp_w);
        tick();
        chk("pin_done_clear", check_done, 0);
        chk("pin_authed", authed, m_auth);
        chk("pin_locked", locked, m_lk);
    endtask

    task automatic commit(input logic [19:0] b);
        commit_en = 1'b1; commit_balance = b;
        tick();
        commit_en = 1'b0;
        if (m_auth) begin
            m_bal[m_sid] = b; m_cur = b;
        end
        chk("commit_balance", current_balance, m_cur);
    endtask

    task automatic remove(input bit pv, input bit ce, input logic [19:0] b);
        card_in = 1'b0; pin_valid = pv; commit_en = ce; commit_balance = b;
        tick();
        pin_valid = 1'b0; commit_en = 1'b0;
        if (ce && m_auth) m_bal[m_sid] = b;
        m_in = 1'b0; m_auth = 1'b0; m_lk = 1'b0; m_cur = '0;
        chk("rm_check_done", check_done, 0);
        chk("rm_busy", busy, 0);
        chk("rm_authed", authed, 0);
        chk("rm_locked", locked, 0);
        chk("rm_balance", current_balance, 0);
    endtask

    // Provisioning attempted while a card is present must not touch any account.
    task automatic prov_ignored(input int id);
        prov_en = 1'b1; prov_id = 2'(id); prov_pin = 16'(~m_pin[id]); prov_balance = 20'(~m_bal[id]);
        tick();
        prov_en = 1'b0;
        chk("provig_authed", authed, m_auth);
        chk("provig_balance", current_balance, m_cur);
    endtask

    initial begin
        model_clear();
        #1;
        chk("rst_balance", current_balance, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {check_done, wrong_psw, authed, locked}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Successful login and balance commit round trip.
        prov(1, 16'h1234, 20'd5000);
        insert(1);
        enter_pin(16'h1234);
        commit(20'd3500);
        remove(0, 0, '0);
        insert(1);
        chk("reload_3500", current_balance, 20'd3500);
        remove(0, 0, '0);

        // Three wrong PINs lock card 2; the correct PIN is then refused.
        prov(2, 16'(16'hA000 + $urandom_range(0, 255)), 20'($urandom));
        insert(2);
        for (int i = 0; i < 3; i++) enter_pin(m_pin[2] ^ 16'h0001);
        chk("lock_after_three", locked, 1);
        enter_pin(m_pin[2]);
        chk("locked_no_auth", authed, 0);
        remove(0, 0, '0);

        // Fail count persists across sessions; provisioning clears the lock.
        prov(2, 16'h0BEE, 20'd77);
        insert(2);
        enter_pin(16'h0BEF); enter_pin(16'h0BED);
        remove(0, 0, '0);
        insert(2);
        enter_pin(16'h1BEE);
        chk("persist_lock", locked, 1);
        remove(0, 0, '0);
        prov(2, 16'h0BEE, 20'd77);
        insert(2);
        enter_pin(16'h0BEE);
        chk("reprov_auth", authed, 1);

        // Removal races: commit is kept, pin_valid is dropped.
        remove(0, 1, 20'd4242);
        insert(2);
        chk("race_commit", current_balance, 20'd4242);
        remove(1, 0, '0);
        tick();
        chk("race_pin_idle", check_done, 0);

        // Provisioning with a card present, then reset in the middle of AUTH.
        insert(1);
        prov_ignored(1);
        enter_pin(16'h1234);
        chk("provig_pin_kept", authed, 1);
        rst = 1'b1; card_in = 1'b0;
        #1;
        chk("midrst_outputs", {check_done, wrong_psw, authed, locked, busy}, 0);
        chk("midrst_balance", current_balance, 0);
        tick();
        rst = 1'b0;
        model_clear();
        tick();
        insert(1);
        chk("post_rst_bal", current_balance, 0);
        enter_pin(16'h0000);
        remove(0, 0, '0);

        // Random sessions; small PIN alphabet so guesses hit often.
        for (int n = 0; n < 250; n++) begin
            if (!m_in) begin
                if ($urandom_range(0, 2) == 0)
                    prov($urandom_range(0, 3), 16'($urandom_range(0, 3)), 20'($urandom));
                else
                    insert($urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 5))
                    0, 1, 2: enter_pin($urandom_range(0, 1) ? m_pin[m_sid] : 16'($urandom_range(0, 3)));
                    3:       commit(20'($urandom));
                    4:       remove(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom));
                    default: prov_ignored($urandom_range(0, 3));
                endcase
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
